// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch pipeline.
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_INC = 4;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef logic [INST_W-1:0] inst_t;

  function automatic logic is_jump(input inst_t inst);
    return (inst[31:26] == OP_J) || (inst[31:26] == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: circular buffer of (instruction, PC) pairs with occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     flush,
  input  logic                     push,
  input  inst_t                    push_inst,
  input  logic [AW-1:0]            push_pc,
  input  logic                     pop,
  output inst_t                    head_inst,
  output logic [AW-1:0]            head_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  inst_t         mem_inst [DEPTH];
  logic [AW-1:0] mem_pc   [DEPTH];
  logic [PW-1:0] wrptr;
  logic [PW-1:0] rdptr;
  logic          do_push;
  logic          do_pop;

  // Pop is qualified by occupancy; push may proceed when full only if a pop frees the slot.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_inst[wrptr] <= push_inst;
      mem_pc[wrptr]   <= push_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (clr || flush) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wrptr <= wrptr + 1'b1;
      if (do_pop)  rdptr <= rdptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_inst = mem_inst[rdptr];
  assign head_pc   = mem_pc[rdptr];

endmodule

// File: rtl/fetch_pipe.sv
// Instruction fetch front end: PC, request gating, response kill and queue.
// Optional jump predecode enabled by defining FETCH_JUMP_PREDECODE_EN.
module fetch_pipe
  import fetch_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                   Clk,
  input  logic                   Clr,
  input  logic                   Redirect,
  input  logic [AW-1:0]          RedirectPC,
  output logic                   ImemReq,
  output logic [AW-1:0]          ImemAddr,
  input  inst_t                  ImemData,
  output logic                   InstValid,
  input  logic                   InstReady,
  output inst_t                  Inst,
  output logic [AW-1:0]          InstPC,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [AW-1:0] pc;
  logic          inflight;
  logic [AW-1:0] ipc;
  logic          kill;
  logic          enq;
  logic          jump_take;
  logic [AW-1:0] jtarget;
  logic [CW:0]   occ;

  // In-flight responses reserve a queue slot so an accepted response never overflows.
  always_comb begin
    occ     = {1'b0, Count} + {{CW{1'b0}}, inflight};
    ImemReq = !Clr && !Redirect && (occ < DEPTH_V);
    enq     = inflight && !kill && !Redirect && !Clr;
  end

  assign ImemAddr = pc;

`ifdef FETCH_JUMP_PREDECODE_EN
  logic [AW-1:0] seq_pc;
  always_comb begin
    seq_pc    = ipc + AW'(PC_INC);
    jump_take = enq && is_jump(ImemData);
    jtarget   = {seq_pc[AW-1:28], ImemData[25:0], 2'b00};
  end
`else
  always_comb begin
    jump_take = 1'b0;
    jtarget   = '0;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Clr) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      ipc      <= '0;
      kill     <= 1'b0;
    end else begin
      inflight <= ImemReq;
      kill     <= jump_take;
      if (ImemReq) ipc <= pc;
      // External redirect outranks a predecoded jump; both override sequential advance.
      if (Redirect)       pc <= {RedirectPC[AW-1:2], 2'b00};
      else if (jump_take) pc <= jtarget;
      else if (ImemReq)   pc <= pc + AW'(PC_INC);
    end
  end

  assign InstValid = (Count != '0) && !Redirect && !Clr;

  fetch_fifo #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (Clk),
    .clr       (Clr),
    .flush     (Redirect),
    .push      (enq),
    .push_inst (ImemData),
    .push_pc   (ipc),
    .pop       (InstValid && InstReady),
    .head_inst (Inst),
    .head_pc   (InstPC),
    .count     (Count)
  );

endmodule
